// File: rtl/timer_icb_slave_pkg.sv
// Shared definitions for the timer ICB front end: register offsets, STAT bit
// positions and FSM state encoding.
package timer_icb_slave_pkg;

    localparam logic [1:0] REG_CON  = 2'd0;
    localparam logic [1:0] REG_PRD  = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int STAT_OVF_BIT = 0;
    localparam int STAT_INT_BIT = 1;
    localparam int STAT_W       = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

endpackage

// File: rtl/timer_icb_slave_stat.sv
// Sticky timer status flags (OVF, INT) with write-1-to-clear; a set arriving
// in the same cycle as a clear keeps the flag high.
module timer_icb_stat
    import timer_icb_slave_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ovf_i,
    input  logic              int_i,
    input  logic              clr_en_i,
    input  logic [STAT_W-1:0] clr_mask_i,
    output logic [STAT_W-1:0] stat_o
);

    logic [STAT_W-1:0] set_vec;
    logic [STAT_W-1:0] flag_q;
    logic [STAT_W-1:0] flag_d;

    always_comb begin
        set_vec               = '0;
        set_vec[STAT_OVF_BIT] = ovf_i;
        set_vec[STAT_INT_BIT] = int_i;
    end

    generate
        for (genvar gi = 0; gi < STAT_W; gi++) begin : g_flag
            assign flag_d[gi] = set_vec[gi] | (flag_q[gi] & ~(clr_en_i & clr_mask_i[gi]));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    flag_q[gi] <= 1'b0;
                end else begin
                    flag_q[gi] <= flag_d[gi];
                end
            end
        end
    endgenerate

    assign stat_o = flag_q;

endmodule

// File: rtl/timer_icb_slave.sv
// ICB register front end for the 16-bit timer: decode, write strobes, read mux
// and single-outstanding response FSM. Define TMR_ICB_ERR_EN to flag unmapped accesses.
module timer_icb_slave
    import timer_icb_slave_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ADDR_W-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [DATA_W-1:0] icb_cmd_wdata,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [DATA_W-1:0] icb_rsp_rdata,
    output logic              icb_rsp_err,
    output logic              tmr_con_wr,
    output logic              tmr_prd_wr,
    output logic              tmr_cnt_wr,
    output logic [15:0]       icb_wdat,
    input  logic [15:0]       tmr_con,
    input  logic [15:0]       tmr_prd,
    input  logic [15:0]       tmr_cnt,
    input  logic              tmr_ovf,
    input  logic              tmr_int
);

    state_e            state_q, state_d;
    logic              accept;
    logic              unmapped;
    logic [1:0]        reg_sel;
    logic              wr_hit;
    logic [2:0]        strb_q, strb_d;
    logic [15:0]       wdat_q, wdat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]       rd_mux;
    logic [STAT_W-1:0] stat;
    logic              stat_clr;
    logic              unused_bits;

    assign accept   = icb_cmd_valid & icb_cmd_ready;
    assign unmapped = |icb_cmd_addr[ADDR_W-1:4];
    assign reg_sel  = icb_cmd_addr[3:2];
    assign wr_hit   = accept & ~icb_cmd_read & ~unmapped;
    assign stat_clr = wr_hit & (reg_sel == REG_STAT);

    // Byte lanes below the word offset and the upper data half are don't-care.
    assign unused_bits = ^{icb_cmd_addr[1:0], icb_cmd_wdata[DATA_W-1:16]};

    timer_icb_stat u_stat (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .ovf_i      (tmr_ovf),
        .int_i      (tmr_int),
        .clr_en_i   (stat_clr),
        .clr_mask_i (icb_cmd_wdata[STAT_W-1:0]),
        .stat_o     (stat)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)        state_d = ST_RESP;
            ST_RESP: if (icb_rsp_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        icb_cmd_ready = (state_q == ST_IDLE);
        icb_rsp_valid = (state_q == ST_RESP);
    end

    always_comb begin
        rd_mux = '0;
        if (!unmapped) begin
            case (reg_sel)
                REG_CON:  rd_mux = tmr_con;
                REG_PRD:  rd_mux = tmr_prd;
                REG_CNT:  rd_mux = tmr_cnt;
                default:  rd_mux = {{(16-STAT_W){1'b0}}, stat};
            endcase
        end
    end

    // Strobes are one-shot; wdat and rdata hold until the next accepted command.
    always_comb begin
        strb_d  = '0;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        if (wr_hit && reg_sel != REG_STAT) begin
            strb_d[reg_sel] = 1'b1;
            wdat_d          = icb_cmd_wdata[15:0];
        end
        if (accept) begin
            rdata_d = icb_cmd_read ? {{(DATA_W-16){1'b0}}, rd_mux} : '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            strb_q  <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
        end else begin
            strb_q  <= strb_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
        end
    end

    assign tmr_con_wr    = strb_q[REG_CON];
    assign tmr_prd_wr    = strb_q[REG_PRD];
    assign tmr_cnt_wr    = strb_q[REG_CNT];
    assign icb_wdat      = wdat_q;
    assign icb_rsp_rdata = rdata_q;

`ifdef TMR_ICB_ERR_EN
    logic err_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= unmapped;
        end
    end

    assign icb_rsp_err = err_q;
`else
    assign icb_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_timer_icb_slave.sv
// Self-checking bench for timer_icb_slave: scoreboard of expected responses,
// strobe/handshake checks, STAT W1C and reset-abort scenarios.
module tb_timer_icb_slave;

`ifdef TMR_ICB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [11:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        tmr_con_wr;
    logic        tmr_prd_wr;
    logic        tmr_cnt_wr;
    logic [15:0] icb_wdat;
    logic [15:0] tmr_con;
    logic [15:0] tmr_prd;
    logic [15:0] tmr_cnt;
    logic        tmr_ovf;
    logic        tmr_int;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];

    always #5 sys_clk = ~sys_clk;

    timer_icb_slave dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .tmr_con_wr    (tmr_con_wr),
        .tmr_prd_wr    (tmr_prd_wr),
        .tmr_cnt_wr    (tmr_cnt_wr),
        .icb_wdat      (icb_wdat),
        .tmr_con       (tmr_con),
        .tmr_prd       (tmr_prd),
        .tmr_cnt       (tmr_cnt),
        .tmr_ovf       (tmr_ovf),
        .tmr_int       (tmr_int)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full command/response transaction; strobes are {cnt,prd,con}.
    task automatic xact(input bit rd, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input bit exp_err,
                        input logic [2:0] exp_strb, input logic [15:0] exp_wdat,
                        input int stall, input bit ovf_at_accept);
        rsp_t e;
        int   n;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wd;
        tmr_ovf       = ovf_at_accept;
        n = 0;
        while (!icb_cmd_ready && n < 20) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!icb_cmd_ready) check("cmd_ready_timeout", 32'(icb_cmd_ready), 32'd1);
        @(posedge sys_clk); #1;
        icb_cmd_valid = 1'b0;
        tmr_ovf       = 1'b0;
        check("strobe", 32'({tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}), 32'(exp_strb));
        if (exp_strb != 3'b000) check("wdat", 32'(icb_wdat), 32'(exp_wdat));
        check("rsp_valid", 32'(icb_rsp_valid), 32'd1);
        check("cmd_ready_busy", 32'(icb_cmd_ready), 32'd0);
        if (icb_rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata", icb_rsp_rdata, e.rdata);
            check("err", 32'(icb_rsp_err), 32'(e.err));
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge sys_clk); #1;
            check("stall_strobe", 32'({tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}), 32'd0);
            check("stall_valid", 32'(icb_rsp_valid), 32'd1);
            check("stall_ready", 32'(icb_cmd_ready), 32'd0);
            check("stall_rdata", icb_rsp_rdata, exp_rdata);
        end
        icb_rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        icb_rsp_ready = 1'b0;
        check("done_valid", 32'(icb_rsp_valid), 32'd0);
        check("done_ready", 32'(icb_cmd_ready), 32'd1);
        $display("xact %s addr=%h wdata=%h rdata=%h err=%0d", rd ? "RD" : "WR",
                 addr, wd, icb_rsp_rdata, icb_rsp_err);
    endtask

    task automatic pulse_ovf();
        tmr_ovf = 1'b1;
        @(posedge sys_clk); #1;
        tmr_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst       = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_rsp_ready = 1'b0;
        tmr_con       = 16'h00A5;
        tmr_prd       = 16'h0020;
        tmr_cnt       = 16'h1234;
        tmr_ovf       = 1'b0;
        tmr_int       = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        check("rst_rdata", icb_rsp_rdata, 32'd0);
        check("rst_err", 32'(icb_rsp_err), 32'd0);
        check("rst_strobe", 32'({tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}), 32'd0);
        check("rst_wdat", 32'(icb_wdat), 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // Register writes, upper data bits dropped
        xact(1'b0, 12'h004, 32'h0000_0020, 32'h0, 1'b0, 3'b010, 16'h0020, 0, 1'b0);
        xact(1'b0, 12'h000, 32'hDEAD_0055, 32'h0, 1'b0, 3'b001, 16'h0055, 0, 1'b0);
        xact(1'b0, 12'h008, 32'hFFFF_1111, 32'h0, 1'b0, 3'b100, 16'h1111, 0, 1'b0);

        // Reads, including 5 cycles of response backpressure
        xact(1'b1, 12'h008, 32'h0, 32'h0000_1234, 1'b0, 3'b000, 16'h0, 5, 1'b0);
        xact(1'b1, 12'h000, 32'h0, 32'h0000_00A5, 1'b0, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b1, 12'h004, 32'h0, 32'h0000_0020, 1'b0, 3'b000, 16'h0, 0, 1'b0);

        // STAT: sticky set, clear racing a new overflow, then plain clear
        pulse_ovf();
        xact(1'b1, 12'h00C, 32'h0, 32'h0000_0001, 1'b0, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b0, 12'h00C, 32'h1, 32'h0, 1'b0, 3'b000, 16'h0, 0, 1'b1);
        xact(1'b1, 12'h00C, 32'h0, 32'h0000_0001, 1'b0, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b0, 12'h00C, 32'h1, 32'h0, 1'b0, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b1, 12'h00C, 32'h0, 32'h0000_0000, 1'b0, 3'b000, 16'h0, 0, 1'b0);
        tmr_int = 1'b1;
        @(posedge sys_clk); #1;
        tmr_int = 1'b0;
        xact(1'b1, 12'h00C, 32'h0, 32'h0000_0002, 1'b0, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b0, 12'h00C, 32'h2, 32'h0, 1'b0, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b1, 12'h00C, 32'h0, 32'h0000_0000, 1'b0, 3'b000, 16'h0, 0, 1'b0);

        // Unmapped accesses
        xact(1'b0, 12'h010, 32'h0000_0077, 32'h0, ERR_EN, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b1, 12'h014, 32'h0, 32'h0, ERR_EN, 3'b000, 16'h0, 0, 1'b0);
        xact(1'b1, 12'h008, 32'h0, 32'h0000_1234, 1'b0, 3'b000, 16'h0, 0, 1'b0);

        // Reset while a response is pending
        pulse_ovf();
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 12'h008;
        icb_cmd_wdata = 32'h0000_BEEF;
        @(posedge sys_clk); #1;
        icb_cmd_valid = 1'b0;
        check("pre_rst_strobe", 32'(tmr_cnt_wr), 32'd1);
        sys_rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(icb_rsp_valid), 32'd0);
        check("mid_rst_strobe", 32'({tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        check("post_rst_ready", 32'(icb_cmd_ready), 32'd1);
        check("post_rst_valid", 32'(icb_rsp_valid), 32'd0);
        xact(1'b1, 12'h00C, 32'h0, 32'h0000_0000, 1'b0, 3'b000, 16'h0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
